// File: rtl/data_mem_responder.sv
// Data-memory responder: word-organised RAM served one request at a time after LATENCY wait states.
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned H/HU/W accesses into error completions.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  size_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ready_o,
    output logic        stall_o,
    output logic        err_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int AW    = IDX_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [2:0]        size_q, size_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;

    logic [31:0]       mem_q [DEPTH_WORDS];
    logic [IDX_W-1:0]  idx_s;
    logic [31:0]       rword_s;
    logic              commit_s;
    logic              access_err_s;
    logic              mem_we_s;
    logic [3:0]        be_s;
    logic [31:0]       wlane_s;
    logic              unused_addr_s;

    function automatic logic size_illegal(input logic [2:0] sz, input logic we);
        logic r;
        case (sz)
            3'd0, 3'd1, 3'd2: r = 1'b0;
            3'd4, 3'd5:       r = we;
            default:          r = 1'b1;
        endcase
        return r;
    endfunction

`ifdef DMEM_MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [2:0] sz, input logic [1:0] a);
        logic r;
        case (sz)
            3'd1, 3'd5: r = a[0];
            3'd2:       r = (a != 2'd0);
            default:    r = 1'b0;
        endcase
        return r;
    endfunction

    assign access_err_s = size_illegal(size_q, we_q) | misaligned(size_q, addr_q[1:0]);
`else
    assign access_err_s = size_illegal(size_q, we_q);
`endif

    function automatic logic [31:0] load_fmt(input logic [31:0] word, input logic [2:0] sz,
                                             input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (sz)
            3'd0:    r = {{24{b[7]}}, b};
            3'd4:    r = {24'd0, b};
            3'd1:    r = {{16{h[15]}}, h};
            3'd5:    r = {16'd0, h};
            3'd2:    r = word;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Upper address bits alias onto the RAM and are deliberately dropped.
    assign unused_addr_s = ^addr_i[31:AW];

    assign idx_s    = addr_q[AW-1:2];
    assign rword_s  = mem_q[idx_s];
    assign mem_we_s = commit_s & we_q & ~access_err_s;

    // Byte-enable and lane-replicated write data for the latched store.
    always_comb begin
        be_s    = 4'b0000;
        wlane_s = wdata_q;
        case (size_q)
            3'd0: begin
                be_s    = 4'b0001 << addr_q[1:0];
                wlane_s = {4{wdata_q[7:0]}};
            end
            3'd1: begin
                be_s    = addr_q[1] ? 4'b1100 : 4'b0011;
                wlane_s = {2{wdata_q[15:0]}};
            end
            3'd2: begin
                be_s    = 4'b1111;
                wlane_s = wdata_q;
            end
            default: begin
                be_s    = 4'b0000;
                wlane_s = wdata_q;
            end
        endcase
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_q[idx_s][8*i +: 8] <= wlane_s[8*i +: 8];
                end
            end
        end
    end

    // Next-state and completion logic of the request FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        ready_d  = 1'b0;
        commit_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    size_d  = size_i;
                    addr_d  = addr_i[AW-1:0];
                    wdata_d = wdata_i;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    commit_s = 1'b1;
                    ready_d  = 1'b1;
                    err_d    = access_err_s;
                    rdata_d  = (access_err_s | we_q) ? 32'd0
                                                     : load_fmt(rword_s, size_q, addr_q[1:0]);
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched request and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign rdata_o = rdata_q;
    assign err_o   = err_q;
    assign ready_o = ready_q;
    assign stall_o = (req_i | (state_q != ST_IDLE)) & ~ready_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed cases plus random traffic against a byte-level memory model.
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [2:0]  size_i = 3'd0;
    logic [31:0] addr_i = 32'd0;
    logic [31:0] wdata_i = 32'd0;
    logic [31:0] rdata_o;
    logic        ready_o;
    logic        stall_o;
    logic        err_o;

    int errors = 0;
    int checks = 0;
    logic [7:0] mem_m [int];

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (req_i),
        .we_i    (we_i),
        .size_i  (size_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o),
        .ready_o (ready_o),
        .stall_o (stall_o),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed little-endian memory, result derived from the size code.
    function automatic void model(input logic we, input logic [2:0] sz, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int base, bsel, hsel;
        logic [15:0] h;
        er = (sz == 3'd3) || (sz >= 3'd6) || (we && (sz == 3'd4 || sz == 3'd5));
`ifdef DMEM_MISALIGN_TRAP_EN
        if (((sz == 3'd1 || sz == 3'd5) && a[0]) || (sz == 3'd2 && a[1:0] != 2'd0)) er = 1'b1;
`endif
        rd   = 32'd0;
        base = int'(a & 32'(DEPTH * 4 - 4));
        bsel = base + int'(a[1:0]);
        hsel = base + (a[1] ? 2 : 0);
        if (er) return;
        if (we) begin
            case (sz)
                3'd0: mem_m[bsel] = wd[7:0];
                3'd1: begin mem_m[hsel] = wd[7:0]; mem_m[hsel+1] = wd[15:8]; end
                default: for (int k = 0; k < 4; k++) mem_m[base+k] = wd[8*k +: 8];
            endcase
        end else begin
            h = {mem_m[hsel+1], mem_m[hsel]};
            case (sz)
                3'd0: rd = 32'($signed(mem_m[bsel]));
                3'd4: rd = 32'(mem_m[bsel]);
                3'd1: rd = 32'($signed(h));
                3'd5: rd = 32'(h);
                default: rd = {mem_m[base+3], mem_m[base+2], mem_m[base+1], mem_m[base]};
            endcase
        end
    endfunction

    task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input string tag);
        logic [31:0] erd;
        logic        eer;
        int          n;
        bit          seen;
        model(we, sz, a, wd, erd, eer);
        @(negedge clk);
        req_i = 1'b1; we_i = we; size_i = sz; addr_i = a; wdata_i = wd;
        #1;
        chk({tag, "/stall_req"}, 32'(stall_o), 32'd1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (ready_o) begin
                seen = 1'b1;
            end else begin
                chk({tag, "/stall_busy"}, 32'(stall_o), 32'd1);
                if (n == 1) begin
                    we_i = ~we; addr_i = ~a; wdata_i = ~wd; size_i = sz ^ 3'd1;
                end
            end
        end
        chk({tag, "/latency"}, 32'(n), 32'(LAT + 1));
        chk({tag, "/stall_ready"}, 32'(stall_o), 32'd0);
        chk({tag, "/err"}, 32'(err_o), 32'(eer));
        if (!we || eer) chk({tag, "/rdata"}, rdata_o, erd);
        req_i = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "/ready_drop"}, 32'(ready_o), 32'd0);
        if (!we) chk({tag, "/rdata_hold"}, rdata_o, erd);
    endtask

    initial begin
        logic [31:0] d1;
        logic        e1;
        int          r1, r2;
        logic [2:0]  sizes [8];
        sizes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

        repeat (3) @(posedge clk);
        #1;
        chk("reset/ready", 32'(ready_o), 32'd0);
        chk("reset/err", 32'(err_o), 32'd0);
        chk("reset/rdata", rdata_o, 32'd0);
        chk("reset/stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        access(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, "sw10");
        access(1'b0, 3'd2, 32'h10, 32'h0, "lw10");
        access(1'b1, 3'd2, 32'h20, 32'h80FF7F01, "sw20");
        access(1'b0, 3'd0, 32'h20, 32'h0, "lb20");
        access(1'b0, 3'd0, 32'h21, 32'h0, "lb21");
        access(1'b0, 3'd0, 32'h22, 32'h0, "lb22");
        access(1'b0, 3'd4, 32'h22, 32'h0, "lbu22");
        access(1'b0, 3'd1, 32'h22, 32'h0, "lh22");
        access(1'b0, 3'd5, 32'h22, 32'h0, "lhu22");
        access(1'b1, 3'd2, 32'h30, 32'h11223344, "sw30");
        access(1'b1, 3'd0, 32'h31, 32'h000000AA, "sb31");
        access(1'b0, 3'd2, 32'h30, 32'h0, "lw30a");
        access(1'b1, 3'd1, 32'h32, 32'h00005566, "sh32");
        access(1'b0, 3'd2, 32'h30, 32'h0, "lw30b");
        access(1'b1, 3'd4, 32'h30, 32'hFFFFFFFF, "sbu_illegal");
        access(1'b0, 3'd2, 32'h30, 32'h0, "lw30c");
        access(1'b0, 3'd3, 32'h30, 32'h0, "size3");
        access(1'b0, 3'd2, 32'h1010, 32'h0, "alias");

        // Request held through RESP: second capture happens in the following IDLE cycle.
        model(1'b0, 3'd2, 32'h10, 32'h0, d1, e1);
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; size_i = 3'd2; addr_i = 32'h10;
        r1 = -1;
        r2 = -1;
        for (int e = 1; e <= 30 && r2 < 0; e++) begin
            @(posedge clk);
            #1;
            if (ready_o) begin
                chk("held/rdata", rdata_o, d1);
                if (r1 < 0) r1 = e; else r2 = e;
            end
        end
        req_i = 1'b0;
        chk("held/first", 32'(r1), 32'(LAT + 1));
        chk("held/period", 32'(r2 - r1), 32'(LAT + 2));
        @(posedge clk);

        // Reset just before the commit edge of a store aborts it.
        access(1'b1, 3'd2, 32'h40, 32'hCAFEF00D, "sw40");
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b1; size_i = 3'd2; addr_i = 32'h40; wdata_i = 32'h12345678;
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        req_i = 1'b0;
        #1;
        chk("rst/ready", 32'(ready_o), 32'd0);
        @(posedge clk);
        #1;
        chk("rst/ready_hold", 32'(ready_o), 32'd0);
        chk("rst/rdata", rdata_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        access(1'b0, 3'd2, 32'h40, 32'h0, "lw40");
        access(1'b0, 3'd2, 32'h42, 32'h0, "lw42");
        access(1'b0, 3'd1, 32'h41, 32'h0, "lh41");

        for (int w = 0; w < 16; w++) begin
            access(1'b1, 3'd2, 32'h100 + 32'(4 * w), $urandom, "rnd_init");
        end
        for (int i = 0; i < 60; i++) begin
            access(($urandom_range(0, 2) == 0), sizes[$urandom_range(0, 7)],
                   32'h100 + 32'($urandom_range(0, 63)), $urandom, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
